// File: rtl/muldiv_unit.sv
// Sequential signed multiply/divide unit: Booth radix-2 MUL and restoring DIV on magnitudes,
// one bit per clock, with a final cycle that applies sign fix-ups and registers the result.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic             op_r;
  logic             a_neg;
  logic             q_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The accumulator is one bit wider than the operands so Booth add/subtract of the most
  // negative multiplicand and the shifted partial remainder never overflow.
  always_comb begin
    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b[WIDTH-1] ? -b : b;
    booth_sum = acc;
    case ({q_reg[0], q_1})
      2'b01:   booth_sum = acc + m_reg;
      2'b10:   booth_sum = acc - m_reg;
      default: booth_sum = acc;
    endcase
    rem_sh   = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    rem_ge   = (rem_sh >= m_reg);
    rem_diff = rem_sh - m_reg;
    quot_fix = q_neg ? -q_reg : q_reg;
    rem_fix  = a_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      op_r        <= 1'b0;
      a_neg       <= 1'b0;
      q_neg       <= 1'b0;
      b_zero      <= 1'b0;
      a_r         <= '0;
      acc         <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q_1         <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (accept) begin
        cnt         <= '0;
        div_by_zero <= 1'b0;
        op_r        <= op;
        a_r         <= a;
        a_neg       <= a[WIDTH-1];
        q_neg       <= a[WIDTH-1] ^ b[WIDTH-1];
        b_zero      <= (b == '0);
        acc         <= '0;
        q_1         <= 1'b0;
        if (op) begin
          q_reg <= a_mag;
          m_reg <= {1'b0, b_mag};
        end else begin
          q_reg <= b;
          m_reg <= {a[WIDTH-1], a};
        end
      end else if (state == RUN) begin
        if (last) begin
          if (!op_r) begin
            result_hi <= acc[WIDTH-1:0];
            result_lo <= q_reg;
          end else if (b_zero) begin
            result_hi   <= a_r;
            result_lo   <= '1;
            div_by_zero <= 1'b1;
          end else begin
            result_hi <= rem_fix;
            result_lo <= quot_fix;
          end
        end else begin
          cnt <= cnt + CW'(1);
          if (!op_r) begin
            acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
            q_1   <= q_reg[0];
          end else begin
            acc   <= rem_ge ? rem_diff : rem_sh;
            q_reg <= {q_reg[WIDTH-2:0], rem_ge};
          end
        end
      end
    end
  end

endmodule
